stopwatch_sequencer: RTL and testbench

Synchronous replacement for the toggle-based stopwatch control. It takes three raw pushbuttons (start/stop, lap, clear), then synchronises, debounces and edge-detects each one. A 4-state Moore FSM then drives the time counter's enable and clear and the display's live/frozen control. Everything runs on the single system clock, so no button signal is ever used as a clock.

---
 rtl/stopwatch_sequencer.sv | 132 +++++++++++++
 tb/tb_stopwatch_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_sequencer.sv
// Stopwatch control: three raw buttons are synchronised, debounced and edge-detected,
// then a Moore FSM drives the time counter enable/clear and the display live/frozen control.
//
// state | meaning
// IDLE  | counter stopped, display live, waiting for start
// RUN   | counter running, display live
// LAP   | counter running, display frozen on the lap value
// STOP  | counter halted, display live showing held time
module stopwatch_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       res,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       counter_enable,
  output logic       counter_clear,
  output logic       display_enable,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic             clear_d;
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       s;
  logic [2:0]       db;
  logic [2:0]       db_q;
  logic [2:0]       armed;
  logic [2:0]       press;
  logic [CNT_W-1:0] cnt [3];
  logic [1:0]       prime;
  logic             ev_ss;
  logic             ev_lap;
  logic             ev_clr;

  // bit 0 = start/stop, bit 1 = lap, bit 2 = clear
  assign raw = {btn_clear, btn_lap, btn_start_stop};

  // Arming waits until the synchroniser holds genuine post-reset samples, so a
  // button held through reset must be seen released before it can fire.
  always_ff @(posedge clk) begin
    if (res) begin
      sync1 <= '0;
      s     <= '0;
      db    <= '0;
      db_q  <= '0;
      armed <= '0;
      prime <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      db_q  <= db;
      if (prime != 2'd2) prime <= prime + 2'd1;
      for (int i = 0; i < 3; i++) begin
        if (s[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= s[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
        if ((prime == 2'd2) && !s[i] && !db[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign press  = armed & db & ~db_q;
  assign ev_ss  = press[0];
  assign ev_lap = press[1] & ~press[0];
  assign ev_clr = press[2] & ~press[1] & ~press[0];

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ev_ss) state_d = RUN;
        else if (ev_clr) clear_d = 1'b1;
      end
      RUN: begin
        if (ev_ss) state_d = STOP;
        else if (ev_lap) state_d = LAP;
      end
      LAP: begin
        if (ev_ss) state_d = STOP;
        else if (ev_lap) state_d = RUN;
      end
      STOP: begin
        if (ev_ss) state_d = RUN;
        else if (ev_clr) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q        <= IDLE;
      counter_enable <= 1'b0;
      counter_clear  <= 1'b0;
      display_enable <= 1'b1;
    end else begin
      state_q        <= state_d;
      counter_enable <= (state_d == RUN) || (state_d == LAP);
      counter_clear  <= clear_d;
      display_enable <= (state_d != LAP);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed bench for stopwatch_sequencer with a 4-cycle debounce; observed vector is
// {state, counter_enable, display_enable, counter_clear}.
module tb_stopwatch_sequencer;

  localparam logic [4:0] O_IDLE = 5'b00_0_1_0;
  localparam logic [4:0] O_RUN  = 5'b01_1_1_0;
  localparam logic [4:0] O_LAP  = 5'b10_1_0_0;
  localparam logic [4:0] O_STOP = 5'b11_0_1_0;
  localparam logic [4:0] O_CLR  = 5'b00_0_1_1;
  localparam logic [2:0] B_SS   = 3'b001;
  localparam logic [2:0] B_LAP  = 3'b010;
  localparam logic [2:0] B_CLR  = 3'b100;

  logic       clk;
  logic       res;
  logic       btn_start_stop;
  logic       btn_lap;
  logic       btn_clear;
  logic       counter_enable;
  logic       counter_clear;
  logic       display_enable;
  logic [1:0] state;
  logic [4:0] obs;

  int checks;
  int errors;
  int cc_count;
  int c0;

  stopwatch_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk            (clk),
    .res            (res),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .counter_enable (counter_enable),
    .counter_clear  (counter_clear),
    .display_enable (display_enable),
    .state          (state)
  );

  assign obs = {state, counter_enable, display_enable, counter_clear};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (counter_clear) cc_count++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [2:0] m);
    {btn_clear, btn_lap, btn_start_stop} = m;
  endtask

  // Buttons set before edge 1; returns just after edge 7, buttons still held.
  task automatic push(input logic [2:0] m);
    set_btn(m);
    tick(7);
  endtask

  task automatic release_all();
    set_btn(3'b000);
    tick(12);
  endtask

  task automatic do_reset();
    set_btn(3'b000);
    res = 1'b1;
    tick(3);
    res = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    set_btn(3'b000);
    res = 1'b1;
    tick(3);
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, O_IDLE); end
    res = 1'b0;
    tick(4);
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("FAIL post_reset_idle: got %b expected %b", obs, O_IDLE); end
  endtask

  task automatic test_basic_run();
    set_btn(B_SS);
    tick(6);
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("FAIL run_not_early: got %b expected %b", obs, O_IDLE); end
    tick(1);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL run_at_edge7: got %b expected %b", obs, O_RUN); end
    tick(3);
    release_all();
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL run_held: got %b expected %b", obs, O_RUN); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 4; i++) begin
      btn_lap = ~i[0];
      tick(1);
    end
    btn_lap = 1'b0;
    tick(12);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL bounce_toggle: got %b expected %b", obs, O_RUN); end
    btn_lap = 1'b1;
    tick(3);
    btn_lap = 1'b0;
    tick(12);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL bounce_pulse3: got %b expected %b", obs, O_RUN); end
    btn_lap = 1'b1;
    tick(4);
    btn_lap = 1'b0;
    tick(2);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL pulse4_not_early: got %b expected %b", obs, O_RUN); end
    tick(1);
    checks++;
    if (obs !== O_LAP) begin errors++; $display("FAIL pulse4_accepted: got %b expected %b", obs, O_LAP); end
    tick(12);
  endtask

  task automatic test_full_sequence();
    do_reset();
    push(B_SS);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL seq_start: got %b expected %b", obs, O_RUN); end
    release_all();
    push(B_LAP);
    checks++;
    if (obs !== O_LAP) begin errors++; $display("FAIL seq_lap: got %b expected %b", obs, O_LAP); end
    release_all();
    push(B_LAP);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL seq_lap_back: got %b expected %b", obs, O_RUN); end
    release_all();
    push(B_SS);
    checks++;
    if (obs !== O_STOP) begin errors++; $display("FAIL seq_stop: got %b expected %b", obs, O_STOP); end
    release_all();
    c0 = cc_count;
    push(B_CLR);
    checks++;
    if (obs !== O_CLR) begin errors++; $display("FAIL seq_clear_pulse: got %b expected %b", obs, O_CLR); end
    tick(1);
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("FAIL seq_clear_end: got %b expected %b", obs, O_IDLE); end
    release_all();
    checks++;
    if (cc_count !== c0 + 1) begin errors++; $display("FAIL seq_clear_width: got %0d cycles expected 1", cc_count - c0); end
  endtask

  task automatic test_ignored();
    do_reset();
    push(B_LAP);
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("FAIL lap_in_idle: got %b expected %b", obs, O_IDLE); end
    release_all();
    push(B_SS);
    release_all();
    c0 = cc_count;
    push(B_CLR);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL clear_in_run: got %b expected %b", obs, O_RUN); end
    release_all();
    push(B_LAP);
    release_all();
    push(B_CLR);
    checks++;
    if (obs !== O_LAP) begin errors++; $display("FAIL clear_in_lap: got %b expected %b", obs, O_LAP); end
    release_all();
    checks++;
    if (cc_count !== c0) begin errors++; $display("FAIL clear_ignored_pulses: got %0d expected 0", cc_count - c0); end
    push(B_SS);
    release_all();
    push(B_LAP);
    checks++;
    if (obs !== O_STOP) begin errors++; $display("FAIL lap_in_stop: got %b expected %b", obs, O_STOP); end
    release_all();
  endtask

  task automatic test_simultaneous();
    do_reset();
    push(B_SS);
    release_all();
    push(B_SS | B_LAP);
    checks++;
    if (obs !== O_STOP) begin errors++; $display("FAIL ss_lap_together: got %b expected %b", obs, O_STOP); end
    release_all();
    checks++;
    if (obs !== O_STOP) begin errors++; $display("FAIL lap_not_queued: got %b expected %b", obs, O_STOP); end
    c0 = cc_count;
    push(B_SS | B_CLR);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL ss_clr_together: got %b expected %b", obs, O_RUN); end
    release_all();
    checks++;
    if (cc_count !== c0) begin errors++; $display("FAIL ss_clr_no_pulse: got %0d expected 0", cc_count - c0); end
  endtask

  task automatic test_reset_edges();
    set_btn(B_SS);
    res = 1'b1;
    tick(3);
    res = 1'b0;
    tick(20);
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("FAIL held_through_reset: got %b expected %b", obs, O_IDLE); end
    release_all();
    push(B_SS);
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL repress_after_hold: got %b expected %b", obs, O_RUN); end
    release_all();
    push(B_LAP);
    release_all();
    checks++;
    if (obs !== O_LAP) begin errors++; $display("FAIL lap_before_reset: got %b expected %b", obs, O_LAP); end
    c0 = cc_count;
    res = 1'b1;
    tick(1);
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("FAIL reset_from_lap: got %b expected %b", obs, O_IDLE); end
    res = 1'b0;
    tick(4);
    checks++;
    if (cc_count !== c0) begin errors++; $display("FAIL reset_no_pulse: got %0d expected 0", cc_count - c0); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cc_count = 0;
    c0       = 0;
    res      = 1'b1;
    set_btn(3'b000);
    test_reset();
    test_basic_run();
    test_bounce();
    test_full_sequence();
    test_ignored();
    test_simultaneous();
    test_reset_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
